issue_queue: RTL and testbench
==============================

# issue_queue

Out-of-order issue queue directly downstream of the rename stage. Accepts renamed instructions with physical source tags and readiness bits, and tracks operand readiness via writeback tag broadcasts. Each cycle it selects the oldest fully ready entry and presents it to the execute stage. Flushes completely on branch mispredict.

## Interface
- `ENTRIES`, 8: queue depth; power of two, at least 2.
- `PAYLOAD_W`, `RENAMED_INSTRUCTION_WIDTH`: opaque renamed-instruction payload width.
- `PTAG_W`, 6: physical register tag width.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `renamed_i` in PAYLOAD_W: renamed instruction payload.
- `renamed_v_i` in 1: payload valid.
- `src1_tag_i`, `src2_tag_i` in PTAG_W: physical source tags.
- `src1_rdy_i`, `src2_rdy_i` in 1: source already ready at rename (also used for unused sources).
- `issue_rename_ready_o` out 1: queue can accept this cycle.
- `wb_v_i` in 1: writeback broadcast valid.
- `wb_tag_i` in PTAG_W: physical tag being written.
- `issued_o` out PAYLOAD_W: payload of the selected entry.
- `issued_v_o` out 1: selected entry valid.
- `exec_issue_ready_i` in 1: execute accepts this cycle.
- `mispredict_i` in 1: flush all entries.

## Operation
- Storage is a compacting shift queue. Entry 0 is the oldest. Valid entries are always contiguous in 0..count-1.
- Per entry: payload, two tags, two ready bits, valid.
- **Enqueue:** occurs when `renamed_v_i && issue_rename_ready_o && !mispredict_i`.
  - The new entry is written at index count, or at count-1 if an issue happens the same cycle.
  - Ready bits are latched as `srcN_rdy_i | (wb_v_i && wb_tag_i == srcN_tag_i)`, so a same-cycle wakeup is never lost.
- **Wakeup:** when `wb_v_i` is high, every valid entry whose srcN tag equals `wb_tag_i` sets that ready bit. The bit stays set until the entry leaves the queue.
- **Select:** picks the lowest-index valid entry with both ready bits set (registered state only, unless the configuration macro below is defined).
  - `issued_v_o` = a selected entry exists and `!mispredict_i`.
  - `issued_o` = that entry's payload; it is don't-care when `issued_v_o` is 0.
- **Issue:** occurs when `issued_v_o && exec_issue_ready_i`. The selected entry k is removed, and entries k+1..count-1 shift down by one, carrying their same-cycle wakeup updates.
- **`issue_rename_ready_o`** = `!reset_i && count < ENTRIES`, computed from registered count only. A same-cycle issue does not free a slot for enqueue.
- **Mispredict:** all valid bits are cleared and count becomes 0 at the next edge. Enqueue and issue are both suppressed in that cycle.
- **Count arithmetic:** count is `$clog2(ENTRIES)+1` bits wide. Next count = count + enq - iss. It never exceeds ENTRIES and never underflows.

## Timing
- **Reset:** count = 0 and all valid bits = 0. `issued_v_o` = 0 and `issue_rename_ready_o` = 0 while `reset_i` is high; ready is 1 in the first cycle after reset.
- **Minimum enqueue-to-issue latency:** 1 cycle. An entry enqueued ready at edge t can issue in cycle t+1.
- **Wakeup-to-eligible:** a wakeup in cycle t makes the entry selectable in cycle t+1 (0 cycles with the configuration macro defined).
- **Outputs:** `issued_o` and `issued_v_o` are combinational from registered entries. They also depend on `mispredict_i`, and on `wb_*` when the macro is defined. There is no combinational path from `exec_issue_ready_i` to any output.
- **Stalls:** while `issued_v_o` is high and `exec_issue_ready_i` is low, the entry is held. The selection may change if an older entry becomes ready.
- **Full queue with simultaneous enqueue attempt and issue:** the issue proceeds, the enqueue is not accepted (ready was 0), and count becomes ENTRIES-1.
- **Mispredict during reset:** reset dominates; the result is identical.

## Configuration
- **`ISSUE_WAKEUP_BYPASS_EN`**
  - Defined: select treats a source as ready if its stored bit is set OR `wb_v_i && wb_tag_i` matches the source tag in the current cycle. This gives back-to-back dependent issue.
  - Undefined: select uses stored ready bits only, and wakeup takes effect one cycle later.
  - Enqueue-time wakeup capture behaves the same either way.

## Test plan
- **Reset, then ready enqueue:** reset 2 cycles, then enqueue payload 0xA5 with both rdy=1 and exec ready=1 → `issued_v_o`=1 with `issued_o`=0xA5 in the next cycle; count returns to 0.
- **Fill and full:** enqueue 8 entries with src1 tag 5 not ready and exec ready=1 → `issue_rename_ready_o`=0 after the 8th, and no issue occurs.
  - Then pulse wb tag 5 → all 8 entries issue oldest-first, one per cycle (payloads 0..7 in order), starting in cycle t+1 (t with the macro defined).
- **Out-of-order select:** entry0 waits on tag 3, entry1 is ready → entry1 issues first.
  - Wakeup tag 3 → entry0 issues next; entries after it compact correctly.
- **Enqueue-time wakeup:** enqueue src2 tag 9 rdy=0 with `wb_v_i`=1 and tag 9 in the same cycle → the entry issues next cycle with no further wakeup.
- **Backpressure then mispredict:** 3 ready entries with exec ready=0 → `issued_o` stays on entry0.
  - Assert `mispredict_i` together with `renamed_v_i` → `issued_v_o`=0 that cycle; count=0 and ready=1 the next cycle, and the enqueued instruction is dropped.

Source files
------------

// File: rtl/issue_queue.sv
// ============================================================================
// issue_queue
// ----------------------------------------------------------------------------
// Out-of-order issue queue sitting directly behind the rename stage. Renamed
// instructions are held together with their physical source tags and operand
// ready bits. Writeback tag broadcasts wake up waiting operands, and each
// cycle the oldest entry whose operands are both ready is offered to execute.
// A branch mispredict empties the whole queue.
//
// Storage is a compacting shift queue. Entry 0 is always the oldest, and the
// valid entries always occupy indices 0..count-1. When an entry issues, every
// younger entry moves down one slot.
//
// Configuration macro:
//   ISSUE_WAKEUP_BYPASS_EN - when defined, select also treats a source as ready
//                            if this cycle's writeback broadcast matches its
//                            tag. This allows back-to-back dependent issue.
//                            When undefined, select looks only at the stored
//                            ready bits, so a wakeup takes effect one cycle
//                            later. Capturing a wakeup at enqueue time works
//                            the same way in both builds.
//
// Parameters:
//   ENTRIES   - queue depth (power of two, >= 2)
//   PAYLOAD_W - opaque renamed-instruction payload width
//   PTAG_W    - physical register tag width
//
// Ports:
//   clk_i                - clock, all state updates on the rising edge
//   reset_i              - synchronous active-high reset
//   renamed_i            - renamed instruction payload
//   renamed_v_i          - payload valid
//   src1_tag_i/src2_tag_i- physical source tags
//   src1_rdy_i/src2_rdy_i- source already ready at rename
//   issue_rename_ready_o - queue can accept an instruction this cycle
//   wb_v_i               - writeback broadcast valid
//   wb_tag_i             - physical tag being written back
//   issued_o             - payload of the selected entry
//   issued_v_o           - selected entry valid
//   exec_issue_ready_i   - execute accepts the selected entry this cycle
//   mispredict_i         - flush every entry
// ============================================================================

`ifndef RENAMED_INSTRUCTION_WIDTH
`define RENAMED_INSTRUCTION_WIDTH 32
`endif

module issue_queue #(
    parameter int ENTRIES   = 8,
    parameter int PAYLOAD_W = `RENAMED_INSTRUCTION_WIDTH,
    parameter int PTAG_W    = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [PAYLOAD_W-1:0] renamed_i,
    input  logic                 renamed_v_i,
    input  logic [PTAG_W-1:0]    src1_tag_i,
    input  logic [PTAG_W-1:0]    src2_tag_i,
    input  logic                 src1_rdy_i,
    input  logic                 src2_rdy_i,
    output logic                 issue_rename_ready_o,
    input  logic                 wb_v_i,
    input  logic [PTAG_W-1:0]    wb_tag_i,
    output logic [PAYLOAD_W-1:0] issued_o,
    output logic                 issued_v_o,
    input  logic                 exec_issue_ready_i,
    input  logic                 mispredict_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    // ------------------------------------------------------------------------
    // Registered entry state
    // ------------------------------------------------------------------------
    logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
    logic [PTAG_W-1:0]    r_tag1    [ENTRIES];
    logic [PTAG_W-1:0]    r_tag2    [ENTRIES];
    logic [ENTRIES-1:0]   r_rdy1;
    logic [ENTRIES-1:0]   r_rdy2;
    logic [ENTRIES-1:0]   r_valid;
    logic [CNT_W-1:0]     r_count;

    // ------------------------------------------------------------------------
    // Wakeup and select signals
    // ------------------------------------------------------------------------
    logic [ENTRIES-1:0]   w_hit1;
    logic [ENTRIES-1:0]   w_hit2;
    logic [ENTRIES-1:0]   w_rdy1_wk;
    logic [ENTRIES-1:0]   w_rdy2_wk;
    logic [ENTRIES-1:0]   w_sel_rdy1;
    logic [ENTRIES-1:0]   w_sel_rdy2;
    logic [ENTRIES-1:0]   w_eligible;
    logic                 w_sel_found;
    logic [IDX_W-1:0]     w_sel_idx;

    // ------------------------------------------------------------------------
    // Handshake signals
    // ------------------------------------------------------------------------
    logic                 w_enq;
    logic                 w_iss;
    logic [CNT_W-1:0]     w_enq_idx;
    logic [CNT_W-1:0]     w_nxt_count;
    logic                 w_new_rdy1;
    logic                 w_new_rdy2;

    // ------------------------------------------------------------------------
    // Views of the queue shifted down by one entry (entry i sees entry i+1),
    // used to compact the queue on issue, and the computed next state.
    // ------------------------------------------------------------------------
    logic [PAYLOAD_W-1:0] w_up_payload  [ENTRIES];
    logic [PTAG_W-1:0]    w_up_tag1     [ENTRIES];
    logic [PTAG_W-1:0]    w_up_tag2     [ENTRIES];
    logic [ENTRIES-1:0]   w_up_rdy1;
    logic [ENTRIES-1:0]   w_up_rdy2;
    logic [ENTRIES-1:0]   w_up_valid;

    logic [PAYLOAD_W-1:0] w_nxt_payload [ENTRIES];
    logic [PTAG_W-1:0]    w_nxt_tag1    [ENTRIES];
    logic [PTAG_W-1:0]    w_nxt_tag2    [ENTRIES];
    logic [ENTRIES-1:0]   w_nxt_rdy1;
    logic [ENTRIES-1:0]   w_nxt_rdy2;
    logic [ENTRIES-1:0]   w_nxt_valid;

    // Compare the writeback broadcast against every stored source tag. The
    // resulting hits always feed the stored ready bits, and in the bypass build
    // they also feed select directly.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            w_hit1[i] = wb_v_i && (wb_tag_i == r_tag1[i]);
            w_hit2[i] = wb_v_i && (wb_tag_i == r_tag2[i]);
        end
    end

    assign w_rdy1_wk = r_rdy1 | w_hit1;
    assign w_rdy2_wk = r_rdy2 | w_hit2;

`ifdef ISSUE_WAKEUP_BYPASS_EN
    assign w_sel_rdy1 = w_rdy1_wk;
    assign w_sel_rdy2 = w_rdy2_wk;
`else
    assign w_sel_rdy1 = r_rdy1;
    assign w_sel_rdy2 = r_rdy2;
`endif

    assign w_eligible = r_valid & w_sel_rdy1 & w_sel_rdy2;

    // Priority select of the lowest-index eligible entry. Scanning from the top
    // down lets the last (lowest) hit win.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = IDX_W'(i);
            end
        end
    end

    // Outputs come only from registered state plus mispredict/reset (and the
    // broadcast in the bypass build). exec_issue_ready_i never reaches them.
    assign issued_o             = r_payload[w_sel_idx];
    assign issued_v_o           = w_sel_found && !mispredict_i && !reset_i;
    assign issue_rename_ready_o = !reset_i && (r_count < CNT_W'(ENTRIES));

    // Handshakes. A same-cycle issue does not free a slot for enqueue, because
    // the ready flag above uses only the registered count.
    assign w_enq       = renamed_v_i && issue_rename_ready_o && !mispredict_i;
    assign w_iss       = issued_v_o && exec_issue_ready_i;
    assign w_enq_idx   = w_iss ? (r_count - CNT_W'(1)) : r_count;
    assign w_nxt_count = r_count + CNT_W'(w_enq) - CNT_W'(w_iss);

    // Operand readiness at enqueue also captures a matching broadcast in the
    // same cycle, so that wakeup is never lost.
    assign w_new_rdy1 = src1_rdy_i | (wb_v_i && (wb_tag_i == src1_tag_i));
    assign w_new_rdy2 = src2_rdy_i | (wb_v_i && (wb_tag_i == src2_tag_i));

    // Build the shifted-down view. The top slot has nothing above it, so it
    // becomes empty when it shifts.
    assign w_up_rdy1  = w_rdy1_wk >> 1;
    assign w_up_rdy2  = w_rdy2_wk >> 1;
    assign w_up_valid = r_valid >> 1;

    always_comb begin
        for (int i = 0; i < ENTRIES - 1; i++) begin
            w_up_payload[i] = r_payload[i+1];
            w_up_tag1[i]    = r_tag1[i+1];
            w_up_tag2[i]    = r_tag2[i+1];
        end
        w_up_payload[ENTRIES-1] = '0;
        w_up_tag1[ENTRIES-1]    = '0;
        w_up_tag2[ENTRIES-1]    = '0;
    end

    // Next state for each entry:
    //   - at or above the issuing slot, take the younger neighbour (already
    //     carrying its wakeup update);
    //   - otherwise keep the entry and OR in this cycle's wakeup;
    //   - the enqueue slot (count, or count-1 when an issue happens the same
    //     cycle) is then overwritten with the new instruction.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (w_iss && (i >= int'(w_sel_idx))) begin
                w_nxt_payload[i] = w_up_payload[i];
                w_nxt_tag1[i]    = w_up_tag1[i];
                w_nxt_tag2[i]    = w_up_tag2[i];
                w_nxt_rdy1[i]    = w_up_rdy1[i];
                w_nxt_rdy2[i]    = w_up_rdy2[i];
                w_nxt_valid[i]   = w_up_valid[i];
            end else begin
                w_nxt_payload[i] = r_payload[i];
                w_nxt_tag1[i]    = r_tag1[i];
                w_nxt_tag2[i]    = r_tag2[i];
                w_nxt_rdy1[i]    = w_rdy1_wk[i];
                w_nxt_rdy2[i]    = w_rdy2_wk[i];
                w_nxt_valid[i]   = r_valid[i];
            end

            if (w_enq && (w_enq_idx == CNT_W'(i))) begin
                w_nxt_payload[i] = renamed_i;
                w_nxt_tag1[i]    = src1_tag_i;
                w_nxt_tag2[i]    = src2_tag_i;
                w_nxt_rdy1[i]    = w_new_rdy1;
                w_nxt_rdy2[i]    = w_new_rdy2;
                w_nxt_valid[i]   = 1'b1;
            end
        end
    end

    // State registers. Reset and mispredict both empty the queue. Only the
    // valid bits and the count need clearing, since every other field is
    // ignored while its entry is invalid.
    always_ff @(posedge clk_i) begin
        if (reset_i || mispredict_i) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_nxt_valid;
            r_count <= w_nxt_count;
        end
        r_rdy1 <= w_nxt_rdy1;
        r_rdy2 <= w_nxt_rdy2;
        for (int i = 0; i < ENTRIES; i++) begin
            r_payload[i] <= w_nxt_payload[i];
            r_tag1[i]    <= w_nxt_tag1[i];
            r_tag2[i]    <= w_nxt_tag2[i];
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// ============================================================================
// tb_issue_queue
// ----------------------------------------------------------------------------
// Directed self-checking bench for issue_queue (ENTRIES=8, PAYLOAD_W=8,
// PTAG_W=6). Inputs are driven 1 time unit after each rising edge. Outputs
// are checked once the inputs have settled, well before the next edge.
// ============================================================================

`timescale 1ns/1ps

module tb_issue_queue;

    localparam int ENTRIES   = 8;
    localparam int PAYLOAD_W = 8;
    localparam int PTAG_W    = 6;

    logic                 clk_i;
    logic                 reset_i;
    logic [PAYLOAD_W-1:0] renamed_i;
    logic                 renamed_v_i;
    logic [PTAG_W-1:0]    src1_tag_i;
    logic [PTAG_W-1:0]    src2_tag_i;
    logic                 src1_rdy_i;
    logic                 src2_rdy_i;
    logic                 issue_rename_ready_o;
    logic                 wb_v_i;
    logic [PTAG_W-1:0]    wb_tag_i;
    logic [PAYLOAD_W-1:0] issued_o;
    logic                 issued_v_o;
    logic                 exec_issue_ready_i;
    logic                 mispredict_i;

    int checks = 0;
    int errors = 0;

    issue_queue #(
        .ENTRIES  (ENTRIES),
        .PAYLOAD_W(PAYLOAD_W),
        .PTAG_W   (PTAG_W)
    ) dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .renamed_i           (renamed_i),
        .renamed_v_i         (renamed_v_i),
        .src1_tag_i          (src1_tag_i),
        .src2_tag_i          (src2_tag_i),
        .src1_rdy_i          (src1_rdy_i),
        .src2_rdy_i          (src2_rdy_i),
        .issue_rename_ready_o(issue_rename_ready_o),
        .wb_v_i              (wb_v_i),
        .wb_tag_i            (wb_tag_i),
        .issued_o            (issued_o),
        .issued_v_o          (issued_v_o),
        .exec_issue_ready_i  (exec_issue_ready_i),
        .mispredict_i        (mispredict_i)
    );

    // 10 ns clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Drive one full set of inputs for the current cycle
    task automatic applyStimulus(
        input logic                 rv,
        input logic [PAYLOAD_W-1:0] pl,
        input logic [PTAG_W-1:0]    t1,
        input logic                 r1,
        input logic [PTAG_W-1:0]    t2,
        input logic                 r2,
        input logic                 wv,
        input logic [PTAG_W-1:0]    wt,
        input logic                 ex,
        input logic                 mp
    );
        renamed_v_i        = rv;
        renamed_i          = pl;
        src1_tag_i         = t1;
        src1_rdy_i         = r1;
        src2_tag_i         = t2;
        src2_rdy_i         = r2;
        wb_v_i             = wv;
        wb_tag_i           = wt;
        exec_issue_ready_i = ex;
        mispredict_i       = mp;
        #1;
    endtask

    // No enqueue, no broadcast, no mispredict; only the execute ready level
    task automatic idle(input logic ex);
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, ex, 1'b0);
    endtask

    // Advance to just after the next rising edge
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    // One comparison point
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i = 1'b1;
        idle(1'b0);

        // ---------------- Reset ----------------
        cycle();
        checkOutput("reset_ready", 32'(issue_rename_ready_o), 32'd0);
        checkOutput("reset_issued_v", 32'(issued_v_o), 32'd0);
        cycle();
        reset_i = 1'b0;
        idle(1'b0);
        checkOutput("post_reset_ready", 32'(issue_rename_ready_o), 32'd1);
        checkOutput("post_reset_count", 32'(dut.r_count), 32'd0);

        // ---------------- Ready enqueue, issue next cycle ----------------
        applyStimulus(1'b1, 8'hA5, 6'd1, 1'b1, 6'd2, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("t1_empty_issued_v", 32'(issued_v_o), 32'd0);
        cycle();
        idle(1'b1);
        checkOutput("t1_issued_v", 32'(issued_v_o), 32'd1);
        checkOutput("t1_issued", 32'(issued_o), 32'hA5);
        cycle();
        checkOutput("t1_count", 32'(dut.r_count), 32'd0);
        checkOutput("t1_after_issued_v", 32'(issued_v_o), 32'd0);

        // ---------------- Fill with entries waiting on tag 5 ----------------
        for (int i = 0; i < ENTRIES; i++) begin
            applyStimulus(1'b1, PAYLOAD_W'(i), 6'd5, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
            checkOutput($sformatf("fill_ready_%0d", i), 32'(issue_rename_ready_o), 32'd1);
            checkOutput($sformatf("fill_no_issue_%0d", i), 32'(issued_v_o), 32'd0);
            cycle();
        end
        // Enqueue attempt while full must be refused
        applyStimulus(1'b1, 8'h88, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("full_ready", 32'(issue_rename_ready_o), 32'd0);
        checkOutput("full_issued_v", 32'(issued_v_o), 32'd0);
        cycle();
        checkOutput("full_count", 32'(dut.r_count), 32'd8);

`ifdef ISSUE_WAKEUP_BYPASS_EN
        // Broadcast tag 5 with an enqueue attempt while full; bypass issues entry 0 now
        applyStimulus(1'b1, 8'h99, 6'd0, 1'b1, 6'd0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0);
        checkOutput("drain_v_0", 32'(issued_v_o), 32'd1);
        checkOutput("drain_pl_0", 32'(issued_o), 32'd0);
        cycle();
        checkOutput("full_iss_count", 32'(dut.r_count), 32'd7);
        for (int j = 1; j < ENTRIES; j++) begin
            idle(1'b1);
            checkOutput($sformatf("drain_v_%0d", j), 32'(issued_v_o), 32'd1);
            checkOutput($sformatf("drain_pl_%0d", j), 32'(issued_o), 32'(j));
            cycle();
        end
`else
        // Broadcast tag 5; entries become selectable next cycle
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd5, 1'b1, 1'b0);
        checkOutput("wake_cycle_issued_v", 32'(issued_v_o), 32'd0);
        cycle();
        for (int j = 0; j < ENTRIES; j++) begin
            if (j == 0)
                applyStimulus(1'b1, 8'h99, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
            else
                idle(1'b1);
            checkOutput($sformatf("drain_v_%0d", j), 32'(issued_v_o), 32'd1);
            checkOutput($sformatf("drain_pl_%0d", j), 32'(issued_o), 32'(j));
            cycle();
            if (j == 0)
                checkOutput("full_iss_count", 32'(dut.r_count), 32'd7);
        end
`endif
        idle(1'b1);
        checkOutput("drain_done_v", 32'(issued_v_o), 32'd0);
        checkOutput("drain_done_count", 32'(dut.r_count), 32'd0);

        // ---------------- Out-of-order select ----------------
        applyStimulus(1'b1, 8'h30, 6'd3, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h31, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("ooo_wait_v", 32'(issued_v_o), 32'd0);
        cycle();
        applyStimulus(1'b1, 8'h32, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0);
        checkOutput("ooo_first_v", 32'(issued_v_o), 32'd1);
        checkOutput("ooo_first_pl", 32'(issued_o), 32'h31);
        cycle();
        checkOutput("ooo_count", 32'(dut.r_count), 32'd2);
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0);
`ifdef ISSUE_WAKEUP_BYPASS_EN
        checkOutput("ooo_wake_pl", 32'(issued_o), 32'h30);
`else
        checkOutput("ooo_wake_pl", 32'(issued_o), 32'h32);
`endif
        cycle();
        idle(1'b1);
        checkOutput("ooo_second_pl", 32'(issued_o), 32'h30);
        cycle();
        idle(1'b1);
        checkOutput("ooo_compact_v", 32'(issued_v_o), 32'd1);
        checkOutput("ooo_compact_pl", 32'(issued_o), 32'h32);
        cycle();
        checkOutput("ooo_empty_count", 32'(dut.r_count), 32'd0);

        // ---------------- Enqueue-time wakeup capture ----------------
        applyStimulus(1'b1, 8'h49, 6'd0, 1'b1, 6'd9, 1'b0, 1'b1, 6'd9, 1'b1, 1'b0);
        cycle();
        idle(1'b1);
        checkOutput("enqwake_v", 32'(issued_v_o), 32'd1);
        checkOutput("enqwake_pl", 32'(issued_o), 32'h49);
        cycle();
        checkOutput("enqwake_count", 32'(dut.r_count), 32'd0);

        // ---------------- Backpressure then mispredict ----------------
        applyStimulus(1'b1, 8'h50, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b1, 8'h51, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        checkOutput("bp_hold_pl_a", 32'(issued_o), 32'h50);
        cycle();
        applyStimulus(1'b1, 8'h52, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle();
        idle(1'b0);
        checkOutput("bp_hold_v", 32'(issued_v_o), 32'd1);
        checkOutput("bp_hold_pl_b", 32'(issued_o), 32'h50);
        checkOutput("bp_count", 32'(dut.r_count), 32'd3);
        applyStimulus(1'b1, 8'h5F, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1);
        checkOutput("mp_issued_v", 32'(issued_v_o), 32'd0);
        cycle();
        idle(1'b1);
        checkOutput("mp_count", 32'(dut.r_count), 32'd0);
        checkOutput("mp_ready", 32'(issue_rename_ready_o), 32'd1);
        checkOutput("mp_dropped_v", 32'(issued_v_o), 32'd0);
        cycle();
        checkOutput("mp_still_empty_v", 32'(issued_v_o), 32'd0);

        // ---------------- Reset with mispredict while an entry is held ----------------
        applyStimulus(1'b1, 8'h60, 6'd0, 1'b1, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        cycle();
        reset_i = 1'b1;
        applyStimulus(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        checkOutput("rst_held_issued_v", 32'(issued_v_o), 32'd0);
        checkOutput("rst_held_ready", 32'(issue_rename_ready_o), 32'd0);
        cycle();
        reset_i = 1'b0;
        idle(1'b1);
        checkOutput("rst_done_count", 32'(dut.r_count), 32'd0);
        checkOutput("rst_done_issued_v", 32'(issued_v_o), 32'd0);
        checkOutput("rst_done_ready", 32'(issue_rename_ready_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
